acc_group_broadcast: RTL and testbench
======================================

# acc_group_broadcast

Parametrised group accumulator with broadcast. It sums a signed local partial sum across each group of 1..MAX_GRP consecutive valid beats, then writes the group total back onto every beat of that group. All beats leave after a fixed MAX_GRP-cycle latency, with a wide bypass bus and per-beat group flags travelling alongside. It sits between the tree-reduction stage and the normalisation stage of the softmax datapath. Compared with the previous fixed 12-deep block, it adds:
- configurable depth and widths;
- a per-group latched length;
- a saturating wide accumulator with overflow flag;
- explicit abort signalling.

## Interface
- SUM_W, 32, width of local and global sums (signed two's complement)
- BYP_W, 1024, width of the bypass payload
- MAX_GRP, 12, maximum group length; also the pipeline latency (≥2)
- LEN_W, $clog2(MAX_GRP+1), width of the group-length field
- i_clk  in  1  clock
- i_rst  in  1  reset: synchronous, active-high; clock i_clk
- i_en  in  1  global advance enable; when low, all state holds
- i_valid  in  1  input beat valid
- i_loc_sum  in  SUM_W  signed local partial sum of this beat
- i_grp_len  in  LEN_W  group length in beats; 0 or 1 means ungrouped
- i_byp  in  BYP_W  payload bypassed with the beat
- o_valid  out  1  output beat valid
- o_global_sum  out  SUM_W  group total, or own sum if ungrouped or aborted
- o_grp_len  out  LEN_W  i_grp_len of this beat, delayed
- o_byp  out  BYP_W  i_byp of this beat, delayed
- o_first  out  1  beat is first of its group
- o_last  out  1  beat is last of its group
- o_ovf  out  1  group total was saturated
- o_abort  out  1  beat belonged to an aborted partial group

## Operation
**Pipeline and advance**
- Each sideband is a MAX_GRP-slot shift register: valid, grp_len, byp, first, last, ovf, abort.
- The sum is held in a separate MAX_GRP-slot register s[0..MAX_GRP-1].
- All registers advance only on cycles with i_en=1, called enabled cycles.

**Bubbles**
- A bubble (i_valid=0) enters slot 0 with all fields zero.

**Group control**
- Registers: cnt (LEN_W) and acc, which is signed SUM_W+LEN_W bits and cannot overflow internally.
- L is latched from i_grp_len on the first beat of a group (cnt==0). i_grp_len on later beats is bypassed but ignored for control.
- Ungrouped beat (L≤1):
  - s[0]=i_loc_sum.
  - first=last=1, ovf=0.
  - cnt and acc stay 0.
- Non-final grouped beat (cnt<L-1):
  - acc+=sext(i_loc_sum); cnt++.
  - s[0]=i_loc_sum.
  - first=(cnt==0), last=0.
- Final beat (cnt==L-1):
  - Compute T = acc + sext(i_loc_sum).
  - Saturate T to the SUM_W signed range: clamp to 2^(SUM_W-1)-1 or -2^(SUM_W-1). ovf = clamp occurred.
  - In the same edge, write the saturated T into post-shift slots s[0..L-1]. Write ovf into ovf-slots 0..L-1.
  - Set last=1 in slot 0. Set first=1 if L==1 (not reachable; L≥2 here).
  - Clear cnt and acc.

**Abort**
- Trigger: an enabled cycle with i_valid=0 while cnt>0.
- Post-shift abort slots 1..cnt are set to 1.
- Those beats keep their own local sums.
- cnt and acc are cleared; the bubble enters slot 0 normally.

**Outputs**
- All outputs come from slot MAX_GRP-1.
- Every member of a completed group therefore leaves carrying T.

**Constraints and reset**
- i_grp_len > MAX_GRP is illegal. The block clamps L to MAX_GRP.
- Reset clears every slot, cnt, acc and L. All outputs read 0 on the cycle after the reset edge.
- Reset mid-group discards partial groups with no abort flag.

## Timing
- Latency: a beat entering on enabled cycle n exits on enabled cycle n+MAX_GRP.
- There is no back-pressure. i_en gates the whole block uniformly.
- The final beat's write-back and shift happen in one edge. The earliest group member is at slot L-1 ≤ MAX_GRP-1, so no beat exits before its total is written.
- i_en=0 on a cycle carrying a final beat: no accumulation and no write-back. The beat is not consumed.
- Back-to-back groups need no idle cycle. The beat after a final beat starts a new group, with L latched from it.
- Abort and new-group start cannot coincide, because an abort requires i_valid=0.

## Test plan
- **Ungrouped pass-through.** MAX_GRP=12, L=1, sums 5,-3,7 on consecutive cycles.
  - Required: after 12 cycles, o_global_sum = 5,-3,7.
  - Required: first=last=1, ovf=abort=0.
- **Group of 4.** Sums 1,2,3,4, L=4.
  - Required: four outputs all = 10, from cycle 12 to cycle 15.
  - Required: first on beat 0, last on beat 3.
  - Required: o_byp and o_grp_len match inputs.
- **Full depth back-to-back.** L=12 with sums 1..12, then immediately L=2 with sums 100,-50.
  - Required: twelve outputs of 78, then two outputs of 50, with no bubble.
- **Saturation.** L=3, sums 0x7FFFFFF0, 0x10, 0x10.
  - Required: all three outputs = 0x7FFFFFFF with o_ovf=1.
  - Required: a negative mirror case gives 0x80000000.
- **Abort.** L=5, sums 1,2,3, then i_valid=0, then a new L=2 group with sums 4,4.
  - Required: three outputs 1,2,3 with abort=1, then a bubble, then 8,8 with abort=0.
- **Stall and reset.** Inside an L=4 group, drop i_en for 3 cycles.
  - Required: outputs hold and totals are unchanged.
  - Then assert i_rst mid-group. Required: all outputs are 0 the next cycle and no stale total appears later.

Source files
------------

// File: rtl/acc_group_broadcast.sv
// Group accumulator: sums signed partial sums over 1..MAX_GRP beats and broadcasts the
// saturated total back onto every beat of the group; fixed MAX_GRP-cycle latency, i_en stalls all.
module acc_group_broadcast #(
  parameter int SUM_W   = 32,
  parameter int BYP_W   = 1024,
  parameter int MAX_GRP = 12,
  parameter int LEN_W   = $clog2(MAX_GRP + 1)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en,
  input  logic             i_valid,
  input  logic [SUM_W-1:0] i_loc_sum,
  input  logic [LEN_W-1:0] i_grp_len,
  input  logic [BYP_W-1:0] i_byp,
  output logic             o_valid,
  output logic [SUM_W-1:0] o_global_sum,
  output logic [LEN_W-1:0] o_grp_len,
  output logic [BYP_W-1:0] o_byp,
  output logic             o_first,
  output logic             o_last,
  output logic             o_ovf,
  output logic             o_abort
);

  localparam int AW = SUM_W + LEN_W;
  localparam logic [LEN_W-1:0] MAX_L = LEN_W'(MAX_GRP);
  localparam logic [LEN_W-1:0] ONE_L = LEN_W'(1);
  localparam logic signed [AW-1:0] SAT_HI = {{(LEN_W+1){1'b0}}, {(SUM_W-1){1'b1}}};
  localparam logic signed [AW-1:0] SAT_LO = {{(LEN_W+1){1'b1}}, {(SUM_W-1){1'b0}}};
  localparam logic [SUM_W-1:0] SUM_MAX = {1'b0, {(SUM_W-1){1'b1}}};
  localparam logic [SUM_W-1:0] SUM_MIN = {1'b1, {(SUM_W-1){1'b0}}};

  // Pipeline slots: index 0 is the newest beat, MAX_GRP-1 drives the outputs.
  logic [MAX_GRP-1:0] vld_q, vld_d;
  logic [MAX_GRP-1:0] first_q, first_d;
  logic [MAX_GRP-1:0] last_q, last_d;
  logic [MAX_GRP-1:0] ovf_q, ovf_d;
  logic [MAX_GRP-1:0] abort_q, abort_d;
  logic [SUM_W-1:0]   s_q   [MAX_GRP];
  logic [SUM_W-1:0]   s_d   [MAX_GRP];
  logic [LEN_W-1:0]   len_q [MAX_GRP];
  logic [LEN_W-1:0]   len_d [MAX_GRP];
  logic [BYP_W-1:0]   byp_q [MAX_GRP];
  logic [BYP_W-1:0]   byp_d [MAX_GRP];

  // Group control state.
  logic [LEN_W-1:0]     cnt_q, cnt_d;
  logic [LEN_W-1:0]     l_q, l_d;
  logic signed [AW-1:0] acc_q, acc_d;

  logic [LEN_W-1:0]     len_clamped;
  logic [LEN_W-1:0]     l_eff;
  logic                 grouped;
  logic                 is_final;
  logic                 is_mid;
  logic                 abort_trig;
  logic signed [AW-1:0] loc_ext;
  logic signed [AW-1:0] tot;
  logic                 sat_hi;
  logic                 sat_lo;
  logic                 tot_ovf;
  logic [SUM_W-1:0]     tot_sat;

  always_comb begin
    len_clamped = (i_grp_len > MAX_L) ? MAX_L : i_grp_len;
    // Only the first beat of a group decides its length.
    l_eff       = (cnt_q == '0) ? len_clamped : l_q;
    grouped     = (l_eff > ONE_L);
    is_final    = i_valid && grouped && (cnt_q == (l_eff - ONE_L));
    is_mid      = i_valid && grouped && !is_final;
    abort_trig  = !i_valid && (cnt_q != '0);
    loc_ext     = {{LEN_W{i_loc_sum[SUM_W-1]}}, i_loc_sum};
    tot         = acc_q + loc_ext;
    sat_hi      = (tot > SAT_HI);
    sat_lo      = (tot < SAT_LO);
    tot_ovf     = sat_hi || sat_lo;
    if (sat_hi) begin
      tot_sat = SUM_MAX;
    end else if (sat_lo) begin
      tot_sat = SUM_MIN;
    end else begin
      tot_sat = tot[SUM_W-1:0];
    end
  end

  always_comb begin
    vld_d   = vld_q;
    first_d = first_q;
    last_d  = last_q;
    ovf_d   = ovf_q;
    abort_d = abort_q;
    s_d     = s_q;
    len_d   = len_q;
    byp_d   = byp_q;
    cnt_d   = cnt_q;
    l_d     = l_q;
    acc_d   = acc_q;

    if (i_en) begin
      vld_d   = {vld_q[MAX_GRP-2:0], i_valid};
      first_d = {first_q[MAX_GRP-2:0], i_valid && (cnt_q == '0)};
      last_d  = {last_q[MAX_GRP-2:0], i_valid && (!grouped || is_final)};
      ovf_d   = {ovf_q[MAX_GRP-2:0], 1'b0};
      abort_d = {abort_q[MAX_GRP-2:0], 1'b0};
      for (int i = MAX_GRP - 1; i >= 1; i--) begin
        s_d[i]   = s_q[i-1];
        len_d[i] = len_q[i-1];
        byp_d[i] = byp_q[i-1];
      end
      s_d[0]   = i_valid ? i_loc_sum : '0;
      len_d[0] = i_valid ? i_grp_len : '0;
      byp_d[0] = i_valid ? i_byp : '0;

      if (i_valid && (cnt_q == '0)) begin
        l_d = l_eff;
      end

      if (is_mid) begin
        acc_d = tot;
        cnt_d = cnt_q + ONE_L;
      end

      // Members sit in post-shift slots 0..L-1, all still inside the pipe.
      if (is_final) begin
        for (int i = 0; i < MAX_GRP; i++) begin
          if (i < int'(l_eff)) begin
            s_d[i]   = tot_sat;
            ovf_d[i] = tot_ovf;
          end
        end
        cnt_d = '0;
        acc_d = '0;
      end

      // Partial group members now occupy slots 1..cnt behind the bubble.
      if (abort_trig) begin
        for (int i = 1; i < MAX_GRP; i++) begin
          if (i <= int'(cnt_q)) begin
            abort_d[i] = 1'b1;
          end
        end
        cnt_d = '0;
        acc_d = '0;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      vld_q   <= '0;
      first_q <= '0;
      last_q  <= '0;
      ovf_q   <= '0;
      abort_q <= '0;
      for (int i = 0; i < MAX_GRP; i++) begin
        s_q[i]   <= '0;
        len_q[i] <= '0;
        byp_q[i] <= '0;
      end
      cnt_q <= '0;
      l_q   <= '0;
      acc_q <= '0;
    end else begin
      vld_q   <= vld_d;
      first_q <= first_d;
      last_q  <= last_d;
      ovf_q   <= ovf_d;
      abort_q <= abort_d;
      for (int i = 0; i < MAX_GRP; i++) begin
        s_q[i]   <= s_d[i];
        len_q[i] <= len_d[i];
        byp_q[i] <= byp_d[i];
      end
      cnt_q <= cnt_d;
      l_q   <= l_d;
      acc_q <= acc_d;
    end
  end

  assign o_valid      = vld_q[MAX_GRP-1];
  assign o_global_sum = s_q[MAX_GRP-1];
  assign o_grp_len    = len_q[MAX_GRP-1];
  assign o_byp        = byp_q[MAX_GRP-1];
  assign o_first      = first_q[MAX_GRP-1];
  assign o_last       = last_q[MAX_GRP-1];
  assign o_ovf        = ovf_q[MAX_GRP-1];
  assign o_abort      = abort_q[MAX_GRP-1];

endmodule

// File: tb/tb_acc_group_broadcast.sv
// Bench for acc_group_broadcast: group-level reference model with per-cycle compare,
// directed scenarios with literal expectations, then randomized traffic.
module tb_acc_group_broadcast;

  localparam int SUM_W   = 32;
  localparam int BYP_W   = 1024;
  localparam int MAX_GRP = 12;
  localparam int LEN_W   = $clog2(MAX_GRP + 1);

  logic             i_clk = 1'b0;
  logic             i_rst;
  logic             i_en;
  logic             i_valid;
  logic [SUM_W-1:0] i_loc_sum;
  logic [LEN_W-1:0] i_grp_len;
  logic [BYP_W-1:0] i_byp;
  logic             o_valid;
  logic [SUM_W-1:0] o_global_sum;
  logic [LEN_W-1:0] o_grp_len;
  logic [BYP_W-1:0] o_byp;
  logic             o_first;
  logic             o_last;
  logic             o_ovf;
  logic             o_abort;

  acc_group_broadcast #(
    .SUM_W(SUM_W), .BYP_W(BYP_W), .MAX_GRP(MAX_GRP), .LEN_W(LEN_W)
  ) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_en(i_en), .i_valid(i_valid),
    .i_loc_sum(i_loc_sum), .i_grp_len(i_grp_len), .i_byp(i_byp),
    .o_valid(o_valid), .o_global_sum(o_global_sum), .o_grp_len(o_grp_len),
    .o_byp(o_byp), .o_first(o_first), .o_last(o_last), .o_ovf(o_ovf),
    .o_abort(o_abort)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    bit               vld;
    logic [SUM_W-1:0] sum;
    logic [LEN_W-1:0] len;
    logic [BYP_W-1:0] byp;
    bit               first, last, ovf, abort;
  } rec_t;

  typedef struct {
    int               st;
    logic [SUM_W-1:0] sum;
    logic [LEN_W-1:0] len;
    logic [31:0]      tag;
    bit               first, last, ovf, abort;
  } lg_t;

  int   ntests = 0;
  int   nfail  = 0;
  bit   chk_on = 0;
  bit   en_edge = 0;
  int   ecnt = 0;
  rec_t q[$];
  lg_t  olog[$];

  // Model group state: records pushed in entry order; a group is fixed up in place.
  bit     open = 0;
  int     glen = 0;
  int     gstart = 0;
  longint gsum = 0;

  function automatic rec_t blank();
    rec_t r;
    r.vld = 0; r.sum = '0; r.len = '0; r.byp = '0;
    r.first = 0; r.last = 0; r.ovf = 0; r.abort = 0;
    return r;
  endfunction

  function automatic longint sx(logic [SUM_W-1:0] v);
    return longint'($signed(v));
  endfunction

  always @(posedge i_clk) begin
    rec_t        r;
    int          lg;
    longint      smax, smin;
    logic [SUM_W-1:0] ts;
    bit          ov;
    en_edge = 0;
    if (i_rst) begin
      q.delete();
      open = 0;
    end else if (i_en) begin
      en_edge = 1;
      ecnt++;
      r = blank();
      if (i_valid) begin
        r.vld = 1; r.sum = i_loc_sum; r.len = i_grp_len; r.byp = i_byp;
        if (!open) begin
          lg = int'(i_grp_len);
          if (lg > MAX_GRP) lg = MAX_GRP;
          r.first = 1;
          if (lg <= 1) begin
            r.last = 1;
            q.push_back(r);
          end else begin
            open = 1; glen = lg; gstart = q.size(); gsum = sx(i_loc_sum);
            q.push_back(r);
          end
        end else begin
          gsum += sx(i_loc_sum);
          q.push_back(r);
          if (q.size() - gstart == glen) begin
            smax = (longint'(1) <<< (SUM_W - 1)) - 1;
            smin = -(longint'(1) <<< (SUM_W - 1));
            ov = 1;
            if (gsum > smax) ts = SUM_W'(smax);
            else if (gsum < smin) ts = SUM_W'(smin);
            else begin ts = SUM_W'(gsum); ov = 0; end
            for (int k = gstart; k < q.size(); k++) begin
              q[k].sum = ts;
              q[k].ovf = ov;
            end
            q[q.size()-1].last = 1;
            open = 0;
          end
        end
      end else begin
        if (open) begin
          for (int k = gstart; k < q.size(); k++) q[k].abort = 1;
        end
        open = 0;
        q.push_back(r);
      end
    end
  end

  always @(negedge i_clk) begin
    rec_t e;
    lg_t  l;
    int   n;
    if (chk_on) begin
      n = q.size();
      e = (n >= MAX_GRP) ? q[n-MAX_GRP] : blank();
      ntests++;
      if (o_valid !== e.vld || o_global_sum !== e.sum || o_grp_len !== e.len ||
          o_byp !== e.byp || o_first !== e.first || o_last !== e.last ||
          o_ovf !== e.ovf || o_abort !== e.abort) begin
        nfail++;
        $display("FAIL cycle_cmp t=%0t got v=%b sum=%h len=%0d f=%b l=%b ovf=%b ab=%b byp0=%h exp v=%b sum=%h len=%0d f=%b l=%b ovf=%b ab=%b byp0=%h",
                 $time, o_valid, o_global_sum, o_grp_len, o_first, o_last, o_ovf, o_abort, o_byp[31:0],
                 e.vld, e.sum, e.len, e.first, e.last, e.ovf, e.abort, e.byp[31:0]);
      end
      if (o_valid && en_edge) begin
        l.st = ecnt; l.sum = o_global_sum; l.len = o_grp_len; l.tag = o_byp[31:0];
        l.first = o_first; l.last = o_last; l.ovf = o_ovf; l.abort = o_abort;
        olog.push_back(l);
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    ntests++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  task automatic drive(input bit v, input logic [SUM_W-1:0] s, input int len, input logic [31:0] tag);
    i_rst = 0; i_en = 1; i_valid = v; i_loc_sum = s;
    i_grp_len = LEN_W'(len);
    i_byp = {(BYP_W/32){tag}};
    @(negedge i_clk);
  endtask

  task automatic flush(input int n);
    for (int k = 0; k < n; k++) drive(0, '0, 0, 32'h0);
  endtask

  // Checks log entries base..base+n-1 as one group carrying sum.
  task automatic chk_grp(input string nm, input int base, input int n,
                         input logic [SUM_W-1:0] sum, input bit ov, input bit ab);
    for (int k = 0; k < n; k++) begin
      if (base + k < olog.size()) begin
        chk({nm, "_sum"}, 64'(olog[base+k].sum), 64'(sum));
        chk({nm, "_ovf"}, 64'(olog[base+k].ovf), 64'(ov));
        chk({nm, "_abort"}, 64'(olog[base+k].abort), 64'(ab));
        chk({nm, "_first"}, 64'(olog[base+k].first), 64'(k == 0));
        if (!ab) chk({nm, "_last"}, 64'(olog[base+k].last), 64'(k == n - 1));
      end
    end
  endtask

  int b0;

  initial begin
    i_rst = 1; i_en = 0; i_valid = 0; i_loc_sum = '0; i_grp_len = '0; i_byp = '0;
    repeat (2) @(negedge i_clk);
    chk_on = 1;
    chk("rst_valid", 64'(o_valid), 64'd0);
    chk("rst_sum", 64'(o_global_sum), 64'd0);
    i_rst = 0;

    // Ungrouped pass-through.
    olog.delete();
    drive(1, SUM_W'(5), 1, 32'hA0); b0 = ecnt;
    drive(1, SUM_W'(-3), 1, 32'hA1);
    drive(1, SUM_W'(7), 0, 32'hA2);
    flush(14);
    chk("ung_n", 64'(olog.size()), 64'd3);
    if (olog.size() == 3) begin
      chk("ung_lat", 64'(olog[0].st - b0), 64'(MAX_GRP - 1));
      chk("ung_s0", 64'(olog[0].sum), 64'(32'd5));
      chk("ung_s1", 64'(olog[1].sum), 64'(32'hFFFFFFFD));
      chk("ung_s2", 64'(olog[2].sum), 64'(32'd7));
      for (int k = 0; k < 3; k++) begin
        chk("ung_fl", 64'({olog[k].first, olog[k].last, olog[k].ovf, olog[k].abort}), 64'(4'b1100));
      end
    end

    // Group of 4.
    olog.delete();
    for (int k = 1; k <= 4; k++) drive(1, SUM_W'(k), 4, 32'hB0 + 32'(k));
    flush(14);
    chk("g4_n", 64'(olog.size()), 64'd4);
    chk_grp("g4", 0, 4, SUM_W'(10), 0, 0);
    if (olog.size() == 4) begin
      chk("g4_len", 64'(olog[2].len), 64'd4);
      chk("g4_byp", 64'(olog[2].tag), 64'(32'hB3));
    end

    // Full depth followed immediately by a pair.
    olog.delete();
    for (int k = 1; k <= 12; k++) drive(1, SUM_W'(k), (k == 1) ? 12 : 3, 32'hC0);
    drive(1, SUM_W'(100), 2, 32'hC1);
    drive(1, SUM_W'(-50), 2, 32'hC1);
    flush(14);
    chk("fd_n", 64'(olog.size()), 64'd14);
    chk_grp("fd12", 0, 12, SUM_W'(78), 0, 0);
    chk_grp("fd2", 12, 2, SUM_W'(50), 0, 0);
    if (olog.size() == 14) chk("fd_nobubble", 64'(olog[13].st - olog[0].st), 64'd13);

    // Saturation, both signs.
    olog.delete();
    drive(1, 32'h7FFFFFF0, 3, 32'hD0);
    drive(1, 32'h00000010, 3, 32'hD0);
    drive(1, 32'h00000010, 3, 32'hD0);
    drive(1, 32'h80000010, 3, 32'hD1);
    drive(1, 32'hFFFFFFF0, 3, 32'hD1);
    drive(1, 32'hFFFFFFF0, 3, 32'hD1);
    flush(14);
    chk("sat_n", 64'(olog.size()), 64'd6);
    chk_grp("satp", 0, 3, 32'h7FFFFFFF, 1, 0);
    chk_grp("satn", 3, 3, 32'h80000000, 1, 0);

    // Abort then a fresh group.
    olog.delete();
    drive(1, SUM_W'(1), 5, 32'hE0);
    drive(1, SUM_W'(2), 5, 32'hE0);
    drive(1, SUM_W'(3), 5, 32'hE0);
    drive(0, '0, 0, 32'h0);
    drive(1, SUM_W'(4), 2, 32'hE1);
    drive(1, SUM_W'(4), 2, 32'hE1);
    flush(14);
    chk("ab_n", 64'(olog.size()), 64'd5);
    if (olog.size() == 5) begin
      chk("ab_s0", 64'(olog[0].sum), 64'd1);
      chk("ab_s1", 64'(olog[1].sum), 64'd2);
      chk("ab_s2", 64'(olog[2].sum), 64'd3);
      for (int k = 0; k < 3; k++) chk("ab_flag", 64'(olog[k].abort), 64'd1);
      chk("ab_bubble", 64'(olog[3].st - olog[2].st), 64'd2);
      chk_grp("ab_new", 3, 2, SUM_W'(8), 0, 0);
    end

    // Stall inside a group, then stall while its members are leaving.
    olog.delete();
    drive(1, SUM_W'(1), 4, 32'hF0);
    drive(1, SUM_W'(2), 4, 32'hF0);
    i_en = 0; i_valid = 1; i_loc_sum = SUM_W'(3);
    repeat (3) @(negedge i_clk);
    drive(1, SUM_W'(3), 4, 32'hF0);
    drive(1, SUM_W'(4), 4, 32'hF0);
    flush(8);
    chk("stall_pre", 64'(o_global_sum), 64'd10);
    i_en = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge i_clk);
      chk("stall_hold_sum", 64'(o_global_sum), 64'd10);
      chk("stall_hold_first", 64'({o_valid, o_first}), 64'(2'b11));
    end
    flush(14);
    chk("stall_n", 64'(olog.size()), 64'd4);
    chk_grp("stall", 0, 4, SUM_W'(10), 0, 0);

    // Reset while a total is on the outputs and another group is open.
    drive(1, SUM_W'(20), 2, 32'h10);
    drive(1, SUM_W'(22), 2, 32'h10);
    flush(8);
    drive(1, SUM_W'(9), 4, 32'h11);
    drive(1, SUM_W'(9), 4, 32'h11);
    chk("rst_pre", 64'(o_global_sum), 64'd42);
    i_rst = 1; i_valid = 0;
    @(negedge i_clk);
    chk("rst_mid_valid", 64'(o_valid), 64'd0);
    chk("rst_mid_sum", 64'(o_global_sum), 64'd0);
    chk("rst_mid_first", 64'(o_first), 64'd0);
    olog.delete();
    flush(14);
    chk("rst_nostale", 64'(olog.size()), 64'd0);

    // Randomized traffic.
    for (int c = 0; c < 3000; c++) begin
      i_rst   = ($urandom_range(0, 299) == 0);
      i_en    = ($urandom_range(0, 9) != 0);
      i_valid = ($urandom_range(0, 7) != 0);
      i_grp_len = LEN_W'($urandom_range(0, (1 << LEN_W) - 1));
      case ($urandom_range(0, 3))
        0: i_loc_sum = SUM_W'($urandom_range(0, 200)) - SUM_W'(100);
        1: i_loc_sum = SUM_W'($urandom);
        2: i_loc_sum = 32'h7FFFF000 + SUM_W'($urandom_range(0, 4095));
        default: i_loc_sum = 32'h80000000 + SUM_W'($urandom_range(0, 4095));
      endcase
      for (int w = 0; w < BYP_W / 32; w++) i_byp[w*32 +: 32] = $urandom;
      @(negedge i_clk);
    end
    flush(14);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
